// File: rtl/loop_pkg.sv
// Shared definitions for the loop replay unit: state encoding, the default
// buffer depth and the instruction/PC widths.
package loop_pkg;

    localparam int DEPTH_DEFAULT = 8;
    localparam int INSTR_W       = 32;
    localparam int PC_W          = 32;
    localparam int ENTRY_W       = PC_W + INSTR_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_REPLAY  = 2'd2,
        ST_EXIT    = 2'd3
    } state_t;

    // Pointer width for a buffer of the given depth; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/loop_entry_ram.sv
// Loop-body storage: DEPTH entries of {pc, instr}, one synchronous write port
// and one asynchronous read port so replay sees its entry in the same cycle.
module loop_entry_ram
    import loop_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int ADDR_W = ptr_width(DEPTH),
    parameter int WIDTH  = ENTRY_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Store a captured entry on the rising edge.
    // NOTE: the array has no reset; every entry is written before the replay
    // pointer can reach it, so clearing it would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/loop_replay_unit.sv
// Loop replay unit: captures a short backward-branch loop body into a small
// buffer, then replays it to IF/ID while the normal fetch path is held, and
// redirects fetch to the fall-through address when the loop is flushed.
module loop_replay_unit
    import loop_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                capture_valid,
    input  logic [INSTR_W-1:0]  capture_instr,
    input  logic [PC_W-1:0]     capture_pc,
    input  logic                capture_start,
    input  logic [PC_W-1:0]     loop_branch_pc,
    input  logic                loop_close,
    input  logic                flush,
    input  logic                id_ready,
    output logic                replay_valid,
    output logic [INSTR_W-1:0]  replay_instr,
    output logic [PC_W-1:0]     replay_pc,
    output logic                fetch_hold,
    output logic                redirect_valid,
    output logic [PC_W-1:0]     redirect_pc,
    output logic                overflow,
    output logic [7:0]          iter_count
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PC_W-1:0]    branch_pc;
    logic [7:0]         iter_q;
    logic               overflow_q;

    logic               full;
    logic               pc_match;
    logic               last_entry;
    logic               handshake;
    logic               wr_en;
    logic [ENTRY_W-1:0] rd_data;

    assign full       = (count == CNT_W'(DEPTH));
    assign pc_match   = (capture_pc == branch_pc);
    assign last_entry = ({1'b0, rd_ptr} == (count - CNT_W'(1)));
    assign handshake  = replay_valid && id_ready;

    // Decide whether this cycle stores an entry; loop_close wins over capture_valid.
    // NOTE: every signal driven here gets a default first, so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        wr_en = 1'b0;
        if (state == ST_CAPTURE && !flush && !full) begin
            if (loop_close) begin
                wr_en = pc_match;
            end else begin
                wr_en = capture_valid;
            end
        end
    end

    loop_entry_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W),
        .WIDTH  (ENTRY_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data ({capture_pc, capture_instr}),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    // Control FSM: capture, replay and exit sequencing; flush overrides all inputs.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            branch_pc  <= '0;
            iter_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= 1'b0;
            if (flush) begin
                // A replay in flight must still redirect fetch; anything else just aborts.
                state <= (state == ST_REPLAY) ? ST_EXIT : ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (capture_start) begin
                            branch_pc <= loop_branch_pc;
                            count     <= '0;
                            wr_ptr    <= '0;
                            iter_q    <= '0;
                            state     <= ST_CAPTURE;
                        end
                    end
                    ST_CAPTURE: begin
                        if (loop_close) begin
                            if (full) begin
                                overflow_q <= 1'b1;
                                state      <= ST_IDLE;
                            end else if (!pc_match) begin
                                // Not the branch we were tracking: drop the capture silently.
                                state <= ST_IDLE;
                            end else begin
                                wr_ptr <= wr_ptr + PTR_W'(1);
                                count  <= count + CNT_W'(1);
                                rd_ptr <= '0;
                                state  <= ST_REPLAY;
                            end
                        end else if (capture_valid) begin
                            if (full) begin
                                overflow_q <= 1'b1;
                                state      <= ST_IDLE;
                            end else begin
                                wr_ptr <= wr_ptr + PTR_W'(1);
                                count  <= count + CNT_W'(1);
                            end
                        end
                    end
                    ST_REPLAY: begin
                        if (handshake) begin
                            if (last_entry) begin
                                rd_ptr <= '0;
                                if (iter_q != 8'hFF) begin
                                    iter_q <= iter_q + 8'd1;
                                end
                            end else begin
                                rd_ptr <= rd_ptr + PTR_W'(1);
                            end
                        end
                    end
                    ST_EXIT: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Replay outputs follow the state directly so flush and reset drop them at once.
    assign replay_valid   = (state == ST_REPLAY) && !flush;
    assign replay_instr   = (state == ST_REPLAY) ? rd_data[INSTR_W-1:0] : '0;
    assign replay_pc      = (state == ST_REPLAY) ? rd_data[ENTRY_W-1:INSTR_W] : '0;
    assign fetch_hold     = (state == ST_REPLAY) || (state == ST_EXIT);
    assign redirect_valid = (state == ST_EXIT);
    assign redirect_pc    = (state == ST_EXIT) ? (branch_pc + PC_W'(4)) : '0;
    assign overflow       = overflow_q;
    assign iter_count     = iter_q;

endmodule

// File: tb/tb_loop_replay_unit.sv
// Self-checking bench for loop_replay_unit: a directed vector table, directed
// corner-case sequences and a randomized run against a queue-based model.
module tb_loop_replay_unit;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        capture_valid;
    logic [31:0] capture_instr;
    logic [31:0] capture_pc;
    logic        capture_start;
    logic [31:0] loop_branch_pc;
    logic        loop_close;
    logic        flush;
    logic        id_ready;
    logic        replay_valid;
    logic [31:0] replay_instr;
    logic [31:0] replay_pc;
    logic        fetch_hold;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        overflow;
    logic [7:0]  iter_count;

    always #5 clk = ~clk;

    loop_replay_unit #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .capture_valid  (capture_valid),
        .capture_instr  (capture_instr),
        .capture_pc     (capture_pc),
        .capture_start  (capture_start),
        .loop_branch_pc (loop_branch_pc),
        .loop_close     (loop_close),
        .flush          (flush),
        .id_ready       (id_ready),
        .replay_valid   (replay_valid),
        .replay_instr   (replay_instr),
        .replay_pc      (replay_pc),
        .fetch_hold     (fetch_hold),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .overflow       (overflow),
        .iter_count     (iter_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        start;
        logic        cv;
        logic [31:0] pc;
        logic        close;
        logic [31:0] lbpc;
        logic        flush;
        logic        rdy;
        logic        e_rv;
        logic [31:0] e_pc;
        logic        e_hold;
        logic        e_redir;
        logic [31:0] e_rdpc;
        logic        e_ovf;
        logic [7:0]  e_iter;
    } vec_t;

    vec_t vecs [14];

    // Reference model state (loop body as a queue of {pc, instr})
    logic [63:0] body [$];
    int          m_mode;   // 0 idle, 1 capturing, 2 replaying, 3 exiting
    int          m_idx;
    int          m_iter;
    logic [31:0] m_bpc;
    logic        m_ovf;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] exp_i(input logic [31:0] pc);
        return (pc == 32'h0) ? 32'h0 : instr_of(pc);
    endfunction

    function automatic vec_t mkv(input logic start, input logic cv, input logic [31:0] pc,
                                 input logic close, input logic [31:0] lbpc, input logic fl,
                                 input logic rdy, input logic e_rv, input logic [31:0] e_pc,
                                 input logic e_hold, input logic e_redir, input logic [31:0] e_rdpc,
                                 input logic e_ovf, input logic [7:0] e_iter);
        vec_t v;
        v.start = start; v.cv = cv; v.pc = pc; v.close = close; v.lbpc = lbpc;
        v.flush = fl; v.rdy = rdy; v.e_rv = e_rv; v.e_pc = e_pc; v.e_hold = e_hold;
        v.e_redir = e_redir; v.e_rdpc = e_rdpc; v.e_ovf = e_ovf; v.e_iter = e_iter;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_rv, input logic [31:0] e_pc,
                              input logic [31:0] e_instr, input logic e_hold, input logic e_redir,
                              input logic [31:0] e_rdpc, input logic e_ovf, input logic [7:0] e_iter);
        check({tag, ".replay_valid"},   32'(replay_valid),   32'(e_rv));
        check({tag, ".replay_pc"},      replay_pc,           e_pc);
        check({tag, ".replay_instr"},   replay_instr,        e_instr);
        check({tag, ".fetch_hold"},     32'(fetch_hold),     32'(e_hold));
        check({tag, ".redirect_valid"}, 32'(redirect_valid), 32'(e_redir));
        check({tag, ".redirect_pc"},    redirect_pc,         e_rdpc);
        check({tag, ".overflow"},       32'(overflow),       32'(e_ovf));
        check({tag, ".iter_count"},     32'(iter_count),     32'(e_iter));
    endtask

    task automatic idle_inputs();
        capture_valid = 1'b0; capture_instr = '0; capture_pc = '0; capture_start = 1'b0;
        loop_branch_pc = '0; loop_close = 1'b0; flush = 1'b0; id_ready = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a loop at branch pc bpc with n body instructions just below it, then close it.
    task automatic load_loop(input logic [31:0] bpc, input int n);
        capture_start = 1'b1; loop_branch_pc = bpc;
        tick();
        capture_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            capture_valid = 1'b1;
            capture_pc    = bpc - 32'(4 * (n - i));
            capture_instr = instr_of(capture_pc);
            tick();
        end
        capture_valid = 1'b0;
        loop_close    = 1'b1;
        capture_pc    = bpc;
        capture_instr = instr_of(bpc);
        tick();
        loop_close = 1'b0;
    endtask

    // Flush while showing cur_pc, then expect one redirect cycle, then idle.
    task automatic flush_exit(input string tag, input logic [31:0] cur_pc, input logic [31:0] bpc,
                              input logic [7:0] iter);
        flush = 1'b1; id_ready = 1'b1;
        #1;
        check_outs({tag, ".flush"}, 1'b0, cur_pc, exp_i(cur_pc), 1'b1, 1'b0, 32'h0, 1'b0, iter);
        tick();
        flush = 1'b0;
        #1;
        check_outs({tag, ".exit"}, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, bpc + 32'd4, 1'b0, iter);
        tick();
        #1;
        check_outs({tag, ".idle"}, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, iter);
        id_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] bp_pc [7];
        logic        bp_rdy [7];
        logic [7:0]  bp_iter [7];
        logic [31:0] exp_pc;

        idle_inputs();
        reset = 1'b1;
        #2;
        check_outs("reset_held", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 8'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_outs("reset_rel", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 8'd0);
        tick();

        // ---- Table: basic replay then exit on entry 2 ----
        vecs[0]  = mkv(1'b1, 1'b0, 32'h0,   1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 8'd0);
        vecs[1]  = mkv(1'b0, 1'b1, 32'hF4,  1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 8'd0);
        vecs[2]  = mkv(1'b0, 1'b1, 32'hF8,  1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 8'd0);
        vecs[3]  = mkv(1'b0, 1'b1, 32'hFC,  1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 8'd0);
        vecs[4]  = mkv(1'b0, 1'b0, 32'h100, 1'b1, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 8'd0);
        vecs[5]  = mkv(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'hF4,  1'b1, 1'b0, 32'h0,   1'b0, 8'd0);
        vecs[6]  = mkv(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'hF8,  1'b1, 1'b0, 32'h0,   1'b0, 8'd0);
        vecs[7]  = mkv(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'hFC,  1'b1, 1'b0, 32'h0,   1'b0, 8'd0);
        vecs[8]  = mkv(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0,   1'b0, 8'd0);
        vecs[9]  = mkv(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'hF4,  1'b1, 1'b0, 32'h0,   1'b0, 8'd1);
        vecs[10] = mkv(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'hF8,  1'b1, 1'b0, 32'h0,   1'b0, 8'd1);
        vecs[11] = mkv(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'hFC,  1'b1, 1'b0, 32'h0,   1'b0, 8'd1);
        vecs[12] = mkv(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h104, 1'b0, 8'd1);
        vecs[13] = mkv(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 8'd1);

        for (int i = 0; i < 14; i++) begin
            capture_start  = vecs[i].start;
            capture_valid  = vecs[i].cv;
            capture_pc     = vecs[i].pc;
            capture_instr  = instr_of(vecs[i].pc);
            loop_close     = vecs[i].close;
            loop_branch_pc = vecs[i].lbpc;
            flush          = vecs[i].flush;
            id_ready       = vecs[i].rdy;
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].e_rv, vecs[i].e_pc, exp_i(vecs[i].e_pc),
                       vecs[i].e_hold, vecs[i].e_redir, vecs[i].e_rdpc, vecs[i].e_ovf, vecs[i].e_iter);
            tick();
        end
        idle_inputs();

        // ---- Backpressure: three stalled cycles mid-replay ----
        load_loop(32'h300, 2);
        bp_pc   = '{32'h2F8, 32'h2FC, 32'h2FC, 32'h2FC, 32'h2FC, 32'h300, 32'h2F8};
        bp_rdy  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        bp_iter = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1};
        for (int i = 0; i < 7; i++) begin
            id_ready = bp_rdy[i];
            #1;
            check_outs($sformatf("bp%0d", i), 1'b1, bp_pc[i], instr_of(bp_pc[i]), 1'b1, 1'b0,
                       32'h0, 1'b0, bp_iter[i]);
            tick();
        end
        flush_exit("bp", 32'h2FC, 32'h300, 8'd1);

        // ---- Overflow on a ninth capture_valid ----
        capture_start = 1'b1; loop_branch_pc = 32'h400;
        tick();
        capture_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            capture_valid = 1'b1;
            capture_pc    = 32'h3E0 + 32'(4 * i);
            capture_instr = instr_of(capture_pc);
            tick();
        end
        #1;
        check_outs("ovf_full", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 8'd0);
        capture_pc = 32'h500;
        tick();
        capture_valid = 1'b0; id_ready = 1'b1;
        #1;
        check_outs("ovf_cv_pulse", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 8'd0);
        loop_close = 1'b1; capture_pc = 32'h400;
        tick();
        loop_close = 1'b0;
        #1;
        check_outs("ovf_cv_after", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 8'd0);
        tick();
        #1;
        check_outs("ovf_cv_idle", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 8'd0);

        // ---- Overflow on loop_close with a full buffer ----
        id_ready = 1'b0;
        capture_start = 1'b1; loop_branch_pc = 32'h400;
        tick();
        capture_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            capture_valid = 1'b1;
            capture_pc    = 32'h3E0 + 32'(4 * i);
            capture_instr = instr_of(capture_pc);
            tick();
        end
        capture_valid = 1'b0; loop_close = 1'b1; capture_pc = 32'h400;
        tick();
        loop_close = 1'b0; id_ready = 1'b1;
        #1;
        check_outs("ovf_lc_pulse", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 8'd0);
        tick();
        #1;
        check_outs("ovf_lc_after", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 8'd0);
        idle_inputs();
        tick();

        // ---- Collision: capture_valid and loop_close together store only the branch ----
        capture_start = 1'b1; loop_branch_pc = 32'h100;
        tick();
        capture_start = 1'b0;
        capture_valid = 1'b1; capture_pc = 32'hFC; capture_instr = instr_of(32'hFC);
        tick();
        loop_close = 1'b1; capture_pc = 32'h100; capture_instr = instr_of(32'h100);
        tick();
        capture_valid = 1'b0; loop_close = 1'b0; id_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_pc = (i == 1) ? 32'h100 : 32'hFC;
            #1;
            check_outs($sformatf("coll%0d", i), 1'b1, exp_pc, instr_of(exp_pc), 1'b1, 1'b0,
                       32'h0, 1'b0, (i == 2) ? 8'd1 : 8'd0);
            tick();
        end
        flush_exit("coll", 32'h100, 32'h100, 8'd1);

        // ---- Mismatch: close at a PC other than the latched branch ----
        capture_start = 1'b1; loop_branch_pc = 32'h100;
        tick();
        capture_start = 1'b0;
        capture_valid = 1'b1; capture_pc = 32'hFC; capture_instr = instr_of(32'hFC);
        tick();
        capture_valid = 1'b0; loop_close = 1'b1; capture_pc = 32'h200;
        tick();
        loop_close = 1'b0; id_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check_outs($sformatf("mism%0d", i), 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 8'd0);
            tick();
        end
        idle_inputs();

        // ---- Asynchronous reset in the middle of a replay ----
        load_loop(32'h600, 1);
        id_ready = 1'b1;
        tick();
        tick();
        #1;
        check_outs("rst_pre", 1'b1, 32'h5FC, instr_of(32'h5FC), 1'b1, 1'b0, 32'h0, 1'b0, 8'd1);
        #2;
        reset = 1'b1;
        #1;
        check_outs("rst_async", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 8'd0);
        tick();
        reset = 1'b0;
        #1;
        check_outs("rst_rel", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 8'd0);
        id_ready = 1'b0;
        load_loop(32'h700, 1);
        id_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_pc = (i == 1) ? 32'h700 : 32'h6FC;
            #1;
            check_outs($sformatf("rst_restart%0d", i), 1'b1, exp_pc, instr_of(exp_pc), 1'b1, 1'b0,
                       32'h0, 1'b0, (i == 2) ? 8'd1 : 8'd0);
            tick();
        end
        flush_exit("rst_restart", 32'h700, 32'h700, 8'd1);
        idle_inputs();

        // ---- Randomized run against the behavioural model ----
        reset = 1'b1;
        tick();
        reset = 1'b0;
        body.delete();
        m_mode = 0; m_idx = 0; m_iter = 0; m_bpc = '0; m_ovf = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            logic [31:0] e_pc, e_instr;
            capture_start  = ($urandom_range(0, 7) == 0);
            loop_branch_pc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC
                                                          : 32'h1000 + 32'($urandom_range(0, 63) * 4);
            capture_valid  = ($urandom_range(0, 1) == 1);
            capture_pc     = 32'h2000 + 32'($urandom_range(0, 255) * 4);
            capture_instr  = $urandom;
            loop_close     = ($urandom_range(0, 11) == 0);
            if (loop_close && $urandom_range(0, 3) != 0) begin
                capture_pc = m_bpc;
            end
            flush    = ($urandom_range(0, 24) == 0);
            id_ready = ($urandom_range(0, 3) != 0);
            #1;
            e_pc    = (m_mode == 2) ? body[m_idx][63:32] : 32'h0;
            e_instr = (m_mode == 2) ? body[m_idx][31:0]  : 32'h0;
            check_outs($sformatf("rnd%0d", cyc), (m_mode == 2) && !flush, e_pc, e_instr,
                       (m_mode == 2) || (m_mode == 3), m_mode == 3,
                       (m_mode == 3) ? m_bpc + 32'd4 : 32'h0, m_ovf, 8'(m_iter));

            // Advance the model by one clock edge
            m_ovf = 1'b0;
            if (flush) begin
                m_mode = (m_mode == 2) ? 3 : 0;
            end else begin
                case (m_mode)
                    0: if (capture_start) begin
                        m_bpc = loop_branch_pc; body.delete(); m_iter = 0; m_mode = 1;
                    end
                    1: if (loop_close) begin
                        if (body.size() == DEPTH) begin
                            m_ovf = 1'b1; m_mode = 0;
                        end else if (capture_pc != m_bpc) begin
                            m_mode = 0;
                        end else begin
                            body.push_back({capture_pc, capture_instr});
                            m_idx = 0; m_mode = 2;
                        end
                    end else if (capture_valid) begin
                        if (body.size() == DEPTH) begin
                            m_ovf = 1'b1; m_mode = 0;
                        end else begin
                            body.push_back({capture_pc, capture_instr});
                        end
                    end
                    2: if (id_ready) begin
                        m_idx++;
                        if (m_idx == body.size()) begin
                            m_idx = 0;
                            if (m_iter < 255) m_iter++;
                        end
                    end
                    default: m_mode = 0;
                endcase
            end
            tick();
        end
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/loop_replay_unit.md
LOOP_REPLAY_UNIT -- requirements
Module: loop_replay_unit

Interface
REQ-001 Parameter: DEPTH, default 8, number of loop-body entries held (instruction plus PC), closing branch included.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  reset; asynchronous, active-high.
REQ-004 capture_valid  input  1  non-branch loop-body instruction presented for storage.
REQ-005 capture_instr  input  32  instruction word to store.
REQ-006 capture_pc  input  32  PC of capture_instr.
REQ-007 capture_start  input  1  one-cycle pulse: backward branch detected; begin a new capture.
REQ-008 loop_branch_pc  input  32  PC of the loop-closing branch; sampled on capture_start.
REQ-009 loop_close  input  1  closing branch is on capture_instr/capture_pc this cycle; enter replay.
REQ-010 flush  input  1  mispredict or abort from the detector.
REQ-011 id_ready  input  1  downstream IF/ID accepts a replayed instruction.
REQ-012 replay_valid  output  1  replay_instr/replay_pc are valid.
REQ-013 replay_instr  output  32  replayed instruction.
REQ-014 replay_pc  output  32  PC of the replayed instruction.
REQ-015 fetch_hold  output  1  stall the normal fetch path while replaying.
REQ-016 redirect_valid  output  1  one-cycle pulse: fetch must restart at redirect_pc.
REQ-017 redirect_pc  output  32  loop exit address.
REQ-018 overflow  output  1  one-cycle pulse: the loop body exceeded DEPTH and the capture was abandoned.
REQ-019 iter_count  output  8  completed replay iterations; saturates at 255.

Function
REQ-020 The FSM SHALL have four states, IDLE, CAPTURE, REPLAY and EXIT, and flush SHALL take priority over every other input in every state.
REQ-021 IDLE: on capture_start, the unit SHALL latch loop_branch_pc, clear count, wr_ptr and iter_count, and move to CAPTURE; all other inputs are ignored.
REQ-022 CAPTURE: capture_valid SHALL write {capture_pc, capture_instr} at wr_ptr and increment wr_ptr and count.
REQ-023 CAPTURE: capture_valid while count==DEPTH SHALL pulse overflow and return to IDLE without writing.
REQ-024 CAPTURE: loop_close with count<DEPTH SHALL write the branch entry, set count+1, reset rd_ptr to 0 and move to REPLAY; capture_valid is ignored in that cycle.
REQ-025 CAPTURE: loop_close with count==DEPTH SHALL pulse overflow and return to IDLE.
REQ-026 CAPTURE: loop_close when capture_pc differs from the latched branch PC SHALL return to IDLE with no outputs.
REQ-027 CAPTURE/IDLE: flush SHALL return to IDLE with no redirect pulse.
REQ-028 REPLAY: fetch_hold and replay_valid SHALL be 1, and replay_instr/replay_pc SHALL show entry rd_ptr combinationally, giving zero-cycle read latency.
REQ-029 REPLAY: replay_valid&&id_ready SHALL advance rd_ptr, wrapping to 0 after entry count-1 and incrementing iter_count on the wrap (saturating).
REQ-030 REPLAY: when id_ready is 0, rd_ptr and the outputs SHALL hold stable.
REQ-031 REPLAY: flush SHALL move to EXIT; replay_valid SHALL drop combinationally that cycle and the handshake SHALL not advance.
REQ-032 EXIT: the unit SHALL pulse redirect_valid for one cycle with redirect_pc = latched branch PC + 4 (modulo 2^32), keep fetch_hold 1, and then go to IDLE.
REQ-033 In every state other than REPLAY and EXIT, fetch_hold, replay_valid and redirect_valid SHALL be 0.
REQ-034 Pointers SHALL be clog2(DEPTH) bits wide and count SHALL be clog2(DEPTH)+1 bits wide.

Reset
REQ-035 Reset SHALL force the state to IDLE and clear every output, pointer, count, iter_count and the latched PC to 0; buffer contents need not be cleared.
REQ-036 Reset asserted mid-REPLAY SHALL drop replay_valid and fetch_hold immediately, with no redirect pulse.

Structure
REQ-037 A shared package (loop_pkg) SHALL hold the state encoding, the DEPTH default and the 32-bit instruction and PC widths.
REQ-038 Storage SHALL be one sub-module, loop_entry_ram: DEPTH x 64 bits, one synchronous write port and one asynchronous read port.

Verification
REQ-039 Basic replay: start with branch PC 0x100, capture 0xF4/0xF8/0xFC, close at 0x100, id_ready=1 -> replay_pc sequence F4,F8,FC,100,F4 and iter_count=1 after the first wrap.
REQ-040 Backpressure: hold id_ready=0 for 3 cycles mid-replay -> replay_pc stays constant and nothing is skipped or duplicated.
REQ-041 Exit: flush while replaying entry 2 -> replay_valid=0 that cycle, then a one-cycle redirect_valid with redirect_pc=0x104, then IDLE with fetch_hold=0.
REQ-042 Overflow: DEPTH=8, capture 8 instructions, then capture_valid or loop_close -> overflow pulses once, state IDLE, replay_valid never asserts.
REQ-043 Collision and mismatch: capture_valid and loop_close in the same cycle -> only the branch is stored; loop_close with capture_pc=0x200 when the latched PC is 0x100 -> IDLE with no replay.
REQ-044 Reset mid-REPLAY -> all outputs are 0 asynchronously; after release, capture_start restarts cleanly with iter_count=0.
